// File: rtl/ysyx_22040759_define.sv
// Shared decode definitions for the ysyx_22040759 pipeline.
// Bus widths, opcode/funct3 codes and inter-stage bundle layouts.
package ysyx_22040759_define;

    localparam int FS_DS_BUS_W = 96;
    localparam int BR_BUS_W    = 65;
    localparam int DS_ES_BUS_W = 288;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } fs_ds_bus_t;

    typedef struct packed {
        logic        taken;
        logic [63:0] target;
    } br_bus_t;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] rs2_val;
        logic [63:0] rs1_val;
        logic [31:0] inst;
        logic [63:0] pc;
    } ds_es_bus_t;

endpackage

// File: rtl/ysyx_22040759_br_unit.sv
// Branch resolution: condition compare and target adder for JAL/JALR/B*.
// Purely combinational; the caller gates the result with its fire signal.
module ysyx_22040759_br_unit
    import ysyx_22040759_define::*;
(
    input  logic [63:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [63:0] rs1_val_i,
    input  logic [63:0] rs2_val_i,
    input  logic [63:0] imm_i_i,
    input  logic [63:0] imm_b_i,
    input  logic [63:0] imm_j_i,
    output logic        taken_o,
    output logic [63:0] target_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_jal;
    logic       is_jalr;
    logic       is_br;
    logic       cond;

    assign opcode  = inst_i[6:0];
    assign funct3  = inst_i[14:12];
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign is_br   = (opcode == OP_BRANCH);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (rs1_val_i == rs2_val_i);
            F3_BNE:  cond = (rs1_val_i != rs2_val_i);
            F3_BLT:  cond = ($signed(rs1_val_i) <  $signed(rs2_val_i));
            F3_BGE:  cond = ($signed(rs1_val_i) >= $signed(rs2_val_i));
            F3_BLTU: cond = (rs1_val_i <  rs2_val_i);
            F3_BGEU: cond = (rs1_val_i >= rs2_val_i);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        taken_o  = 1'b0;
        target_o = 64'h0;
        unique case (1'b1)
            is_jal: begin
                taken_o  = 1'b1;
                target_o = pc_i + imm_j_i;
            end
            is_jalr: begin
                taken_o  = (funct3 == 3'b000);
                target_o = (rs1_val_i + imm_i_i) & ~64'h1;
            end
            is_br: begin
                taken_o  = cond;
                target_o = pc_i + imm_b_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_22040759_id_stage.sv
// Decode stage: latches fetch bus, resolves control transfers,
// cancels the one wrong-path fetch after a taken transfer.
module ysyx_22040759_id_stage
    import ysyx_22040759_define::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fs_to_ds_valid,
    input  logic [FS_DS_BUS_W-1:0] fs_to_ds_bus,
    output logic                   ds_allowin,
    output logic [BR_BUS_W-1:0]    br_bus,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [63:0]            rf_rdata1,
    input  logic [63:0]            rf_rdata2,
    input  logic                   ds_stall,
    input  logic                   es_allowin,
    output logic                   ds_to_es_valid,
    output logic [DS_ES_BUS_W-1:0] ds_to_es_bus
);

    logic       ds_valid_q;
    logic       ds_valid_d;
    fs_ds_bus_t ds_bus_q;
    fs_ds_bus_t ds_bus_d;
    logic       drop_next_q;
    logic       drop_next_d;

    logic        ds_ready_go;
    logic        fire;
    logic        accept;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] imm_u;
    logic [63:0] imm_j;
    logic [63:0] imm;
    logic        bu_taken;
    logic [63:0] bu_target;
    br_bus_t     br;
    ds_es_bus_t  out_bus;

    assign inst   = ds_bus_q.inst;
    assign pc     = ds_bus_q.pc;
    assign opcode = inst[6:0];

    assign ds_ready_go    = !ds_stall;
    assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid_q && ds_ready_go;
    assign fire           = ds_valid_q && ds_ready_go && es_allowin;
    assign accept         = fs_to_ds_valid && ds_allowin;

    assign rf_raddr1 = inst[19:15];
    assign rf_raddr2 = inst[24:20];

    assign imm_i = {{52{inst[31]}}, inst[31:20]};
    assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{51{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{32{inst[31]}}, inst[31:12], 12'h0};
    assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    always_comb begin
        imm = 64'h0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: imm = imm_i;
            OP_STORE:                           imm = imm_s;
            OP_BRANCH:                          imm = imm_b;
            OP_LUI, OP_AUIPC:                   imm = imm_u;
            OP_JAL:                             imm = imm_j;
            default:                            imm = 64'h0;
        endcase
    end

    ysyx_22040759_br_unit u_br_unit (
        .pc_i      (pc),
        .inst_i    (inst),
        .rs1_val_i (rf_rdata1),
        .rs2_val_i (rf_rdata2),
        .imm_i_i   (imm_i),
        .imm_b_i   (imm_b),
        .imm_j_i   (imm_j),
        .taken_o   (bu_taken),
        .target_o  (bu_target)
    );

    // A transfer only counts when the instruction actually leaves decode.
    assign br.taken  = fire && bu_taken;
    assign br.target = br.taken ? bu_target : 64'h0;
    assign br_bus    = br;

    assign out_bus.imm     = imm;
    assign out_bus.rs2_val = rf_rdata2;
    assign out_bus.rs1_val = rf_rdata1;
    assign out_bus.inst    = inst;
    assign out_bus.pc      = pc;
    assign ds_to_es_bus    = out_bus;

    always_comb begin
        ds_valid_d  = ds_valid_q;
        ds_bus_d    = ds_bus_q;
        drop_next_d = drop_next_q;
        if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid && !drop_next_q;
        end
        if (accept) begin
            ds_bus_d    = fs_to_ds_bus;
            drop_next_d = 1'b0;
        end
        if (br.taken) begin
            drop_next_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ds_valid_q  <= 1'b0;
            ds_bus_q    <= '0;
            drop_next_q <= 1'b0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            ds_bus_q    <= ds_bus_d;
            drop_next_q <= drop_next_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_id_stage.sv
// Directed bench for the decode stage: handshake, immediates,
// branch resolution, wrong-path drop, stall hold and reset.
module tb_ysyx_22040759_id_stage;

    logic         clk;
    logic         rst;
    logic         fs_to_ds_valid;
    logic [95:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic [64:0]  br_bus;
    logic [4:0]   rf_raddr1;
    logic [4:0]   rf_raddr2;
    logic [63:0]  rf_rdata1;
    logic [63:0]  rf_rdata2;
    logic         ds_stall;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [287:0] ds_to_es_bus;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] JAL  = 32'h010000EF;
    localparam logic [31:0] BEQ  = 32'hFE208CE3;
    localparam logic [31:0] BLT  = 32'hFE20CCE3;
    localparam logic [31:0] BLTU = 32'hFE20ECE3;
    localparam logic [31:0] JALR = 32'h002280E7;

    ysyx_22040759_id_stage dut (
        .clk            (clk),
        .rst            (rst),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .ds_stall       (ds_stall),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [63:0] pc);
        fs_to_ds_bus   = {inst, pc};
        fs_to_ds_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (ds_allowin !== 1'b1) $display("FAIL rst_allowin got %b exp 1", ds_allowin);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", ds_to_es_valid);
        else pass_cnt++;
        total_cnt++;
        if (br_bus !== 65'h0) $display("FAIL rst_br got %h exp 0", br_bus);
        else pass_cnt++;
        total_cnt++;
        if (rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd0)
            $display("FAIL rst_raddr got %0d/%0d exp 0/0", rf_raddr1, rf_raddr2);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_bus !== 288'h0) $display("FAIL rst_bus got %h exp 0", ds_to_es_bus);
        else pass_cnt++;
    endtask

    task automatic test_nop();
        present(NOP, 64'h80000000);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        total_cnt++;
        if (ds_to_es_valid !== 1'b1) $display("FAIL nop_valid got %b exp 1", ds_to_es_valid);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_bus[63:0] !== 64'h80000000)
            $display("FAIL nop_pc got %h exp 80000000", ds_to_es_bus[63:0]);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_bus[95:64] !== NOP)
            $display("FAIL nop_inst got %h exp %h", ds_to_es_bus[95:64], NOP);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_bus[287:224] !== 64'h0)
            $display("FAIL nop_imm got %h exp 0", ds_to_es_bus[287:224]);
        else pass_cnt++;
        total_cnt++;
        if (br_bus !== 65'h0) $display("FAIL nop_br got %h exp 0", br_bus);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ds_to_es_valid !== 1'b0) $display("FAIL nop_leave got %b exp 0", ds_to_es_valid);
        else pass_cnt++;
    endtask

    task automatic test_jal();
        present(JAL, 64'h80000004);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        total_cnt++;
        if (br_bus !== {1'b1, 64'h80000014})
            $display("FAIL jal_br got %h exp 1_80000014", br_bus);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_bus[287:224] !== 64'd16)
            $display("FAIL jal_imm got %h exp 10", ds_to_es_bus[287:224]);
        else pass_cnt++;
        tick();
        present(NOP, 64'h80000008);
        #1;
        total_cnt++;
        if (br_bus !== 65'h0) $display("FAIL jal_br_once got %h exp 0", br_bus);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ds_to_es_valid !== 1'b0) $display("FAIL jal_drop got %b exp 0", ds_to_es_valid);
        else pass_cnt++;
        present(NOP, 64'h80000014);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        total_cnt++;
        if (ds_to_es_valid !== 1'b1 || ds_to_es_bus[63:0] !== 64'h80000014)
            $display("FAIL jal_target got %b/%h exp 1/80000014",
                     ds_to_es_valid, ds_to_es_bus[63:0]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_beq();
        rf_rdata1 = 64'd5;
        rf_rdata2 = 64'd5;
        present(BEQ, 64'h80000010);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        total_cnt++;
        if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2)
            $display("FAIL beq_raddr got %0d/%0d exp 1/2", rf_raddr1, rf_raddr2);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_bus[287:224] !== 64'hFFFFFFFFFFFFFFF8)
            $display("FAIL beq_imm got %h exp fffffffffffffff8", ds_to_es_bus[287:224]);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_bus[159:96] !== 64'd5 || ds_to_es_bus[223:160] !== 64'd5)
            $display("FAIL beq_rs got %h/%h exp 5/5",
                     ds_to_es_bus[159:96], ds_to_es_bus[223:160]);
        else pass_cnt++;
        total_cnt++;
        if (br_bus !== {1'b1, 64'h80000008})
            $display("FAIL beq_taken got %h exp 1_80000008", br_bus);
        else pass_cnt++;
        tick();
        present(NOP, 64'h80000014);
        tick();
        fs_to_ds_valid = 1'b0;
        total_cnt++;
        if (ds_to_es_valid !== 1'b0) $display("FAIL beq_drop got %b exp 0", ds_to_es_valid);
        else pass_cnt++;
        rf_rdata2 = 64'd6;
        present(BEQ, 64'h80000010);
        tick();
        present(NOP, 64'h80000014);
        #1;
        total_cnt++;
        if (br_bus !== 65'h0) $display("FAIL beq_not_taken got %h exp 0", br_bus);
        else pass_cnt++;
        total_cnt++;
        if (ds_allowin !== 1'b1) $display("FAIL beq_allowin got %b exp 1", ds_allowin);
        else pass_cnt++;
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        total_cnt++;
        if (ds_to_es_valid !== 1'b1 || ds_to_es_bus[63:0] !== 64'h80000014)
            $display("FAIL beq_no_drop got %b/%h exp 1/80000014",
                     ds_to_es_valid, ds_to_es_bus[63:0]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_blt_bltu();
        rf_rdata1 = 64'hFFFFFFFFFFFFFFFF;
        rf_rdata2 = 64'd1;
        present(BLTU, 64'h80000020);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        total_cnt++;
        if (br_bus !== 65'h0) $display("FAIL bltu_not_taken got %h exp 0", br_bus);
        else pass_cnt++;
        tick();
        present(BLT, 64'h80000020);
        tick();
        fs_to_ds_valid = 1'b0;
        es_allowin = 1'b0;
        #1;
        total_cnt++;
        if (br_bus !== 65'h0) $display("FAIL blt_es_hold_br got %h exp 0", br_bus);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_valid !== 1'b1 || ds_allowin !== 1'b0)
            $display("FAIL blt_es_hold got %b/%b exp 1/0", ds_to_es_valid, ds_allowin);
        else pass_cnt++;
        tick();
        es_allowin = 1'b1;
        #1;
        total_cnt++;
        if (br_bus !== {1'b1, 64'h80000018})
            $display("FAIL blt_taken got %h exp 1_80000018", br_bus);
        else pass_cnt++;
        tick();
        present(NOP, 64'h80000024);
        tick();
        fs_to_ds_valid = 1'b0;
        total_cnt++;
        if (ds_to_es_valid !== 1'b0) $display("FAIL blt_drop got %b exp 0", ds_to_es_valid);
        else pass_cnt++;
    endtask

    task automatic test_jalr();
        rf_rdata1 = 64'h80000101;
        rf_rdata2 = 64'h0;
        present(JALR, 64'h80000030);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        total_cnt++;
        if (rf_raddr1 !== 5'd5) $display("FAIL jalr_raddr got %0d exp 5", rf_raddr1);
        else pass_cnt++;
        total_cnt++;
        if (ds_to_es_bus[287:224] !== 64'd2)
            $display("FAIL jalr_imm got %h exp 2", ds_to_es_bus[287:224]);
        else pass_cnt++;
        total_cnt++;
        if (br_bus !== {1'b1, 64'h80000102})
            $display("FAIL jalr_target got %h exp 1_80000102", br_bus);
        else pass_cnt++;
        tick();
        tick();
        tick();
        present(NOP, 64'h80000102);
        tick();
        fs_to_ds_valid = 1'b0;
        total_cnt++;
        if (ds_to_es_valid !== 1'b0)
            $display("FAIL jalr_drop_held got %b exp 0", ds_to_es_valid);
        else pass_cnt++;
        present(NOP, 64'h80000102);
        tick();
        fs_to_ds_valid = 1'b0;
        total_cnt++;
        if (ds_to_es_valid !== 1'b1) $display("FAIL jalr_after got %b exp 1", ds_to_es_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_stall_reset();
        rf_rdata1 = 64'd5;
        rf_rdata2 = 64'd5;
        ds_stall = 1'b1;
        present(BEQ, 64'h80000040);
        tick();
        present(NOP, 64'h80000044);
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (br_bus !== 65'h0) $display("FAIL stall_br[%0d] got %h exp 0", i, br_bus);
            else pass_cnt++;
            total_cnt++;
            if (ds_allowin !== 1'b0 || ds_to_es_valid !== 1'b0)
                $display("FAIL stall_hs[%0d] got %b/%b exp 0/0", i, ds_allowin, ds_to_es_valid);
            else pass_cnt++;
            total_cnt++;
            if (ds_to_es_bus[63:0] !== 64'h80000040 || ds_to_es_bus[95:64] !== BEQ)
                $display("FAIL stall_bus[%0d] got %h exp %h_80000040",
                         i, ds_to_es_bus[95:0], BEQ);
            else pass_cnt++;
            tick();
        end
        fs_to_ds_valid = 1'b0;
        ds_stall = 1'b0;
        #1;
        total_cnt++;
        if (br_bus !== {1'b1, 64'h80000038})
            $display("FAIL stall_fire got %h exp 1_80000038", br_bus);
        else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b1)
            $display("FAIL mid_rst got %b/%b exp 0/1", ds_to_es_valid, ds_allowin);
        else pass_cnt++;
        present(NOP, 64'h80000100);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        total_cnt++;
        if (ds_to_es_valid !== 1'b1 || ds_to_es_bus[63:0] !== 64'h80000100)
            $display("FAIL rst_no_drop got %b/%h exp 1/80000100",
                     ds_to_es_valid, ds_to_es_bus[63:0]);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus   = '0;
        rf_rdata1      = '0;
        rf_rdata2      = '0;
        ds_stall       = 1'b0;
        es_allowin     = 1'b1;
        test_reset();
        test_nop();
        test_jal();
        test_beq();
        test_blt_bltu();
        test_jalr();
        test_stall_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
